psk_modulator: RTL and testbench



---
 rtl/psk_pkg.sv | 8 +
 rtl/psk_symbol_timer.sv | 31 +++
 rtl/psk_modulator.sv | 84 ++++++++
 tb/tb_psk_modulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// psk_pkg: state encoding and default parameters shared by the BPSK transmitter.
package psk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_t;
  localparam int NCO_WIDTH = 12;
  localparam logic [NCO_WIDTH-1:0] DEF_CTRL_WORD = 12'h100;
  localparam int DEF_SYM_CYCLES = 256;
  localparam int DEF_PREAMBLE_BITS = 8;
endpackage

// File: rtl/psk_symbol_timer.sv
// psk_symbol_timer: clk-per-symbol counter and symbol-in-phase counter with end-of-symbol flags.
module psk_symbol_timer import psk_pkg::*; #(
  parameter int SYM_CYCLES = DEF_SYM_CYCLES,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [BW-1:0] i_last,
  output logic          o_sym_end,
  output logic          o_pre_end,
  output logic          o_last_bit,
  output logic          o_odd
);
  localparam int CW = $clog2(SYM_CYCLES);
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bits;
  assign o_sym_end = i_en && r_cnt == CW'(SYM_CYCLES - 1);
  assign o_pre_end = r_cnt == CW'(SYM_CYCLES - 2);
  assign o_last_bit = r_bits == i_last;
  assign o_odd = r_bits[0];
  always_ff @(posedge clk)
    if (!rst_in || i_clr) begin
      r_cnt <= '0;
      r_bits <= '0;
    end else if (i_en) begin
      r_cnt <= o_sym_end ? '0 : r_cnt + 1'b1;
      if (o_sym_end) r_bits <= o_last_bit ? '0 : r_bits + 1'b1;
    end
endmodule

// File: rtl/psk_modulator.sv
// psk_modulator: byte-serial BPSK burst transmitter with preamble and free-running NCO carrier.
// Define PSK_DIFF_EN for differential (DBPSK) phase encoding.
module psk_modulator import psk_pkg::*; #(
  parameter logic [NCO_WIDTH-1:0] CTRL_WORD = DEF_CTRL_WORD,
  parameter int SYM_CYCLES = DEF_SYM_CYCLES,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [7:0] value,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       sig
);
  localparam int BW = $clog2(PREAMBLE_BITS > 8 ? PREAMBLE_BITS : 8);
  state_t r_state;
  logic [NCO_WIDTH-1:0] r_acc;
  logic [7:0] r_shreg;
  logic r_ready, r_busy, r_sig;
  logic w_accept, w_sym, w_p, w_sym_end, w_pre_end, w_last_bit, w_odd;
  logic [BW-1:0] w_last;
  assign w_accept = valid && r_ready;
  assign w_last = r_state == PREAMBLE ? BW'(PREAMBLE_BITS - 1) : BW'(7);
  assign w_sym = r_state == PREAMBLE ? ~w_odd : r_state == DATA ? r_shreg[7] : 1'b0;
  psk_symbol_timer #(.SYM_CYCLES(SYM_CYCLES), .BW(BW)) u_timer (
    .clk(clk),
    .rst_in(rst_in),
    .i_clr(w_accept && r_state == IDLE),
    .i_en(r_state != IDLE),
    .i_last(w_last),
    .o_sym_end(w_sym_end),
    .o_pre_end(w_pre_end),
    .o_last_bit(w_last_bit),
    .o_odd(w_odd)
  );
`ifdef PSK_DIFF_EN
  logic r_pprev;
  assign w_p = r_pprev ^ w_sym;
  always_ff @(posedge clk)
    r_pprev <= (!rst_in || r_state == IDLE || (r_state == DATA && r_ready && !valid)) ? 1'b0 :
               w_sym_end ? w_p : r_pprev;
`else
  assign w_p = w_sym;
`endif
  // ready is predicted one clk early so it is high exactly in the final clk of each byte
  always_ff @(posedge clk)
    if (!rst_in) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_shreg <= '0;
      r_ready <= 1'b0;
      r_busy <= 1'b0;
      r_sig <= 1'b0;
    end else begin
      r_acc <= r_acc + CTRL_WORD;
      r_sig <= r_acc[NCO_WIDTH-1] ^ w_p;
      case (r_state)
        IDLE: begin
          r_ready <= !w_accept;
          r_busy <= w_accept;
          if (w_accept) begin
            r_shreg <= value;
            r_state <= PREAMBLE_BITS == 0 ? DATA : PREAMBLE;
          end
        end
        PREAMBLE: if (w_sym_end && w_last_bit) r_state <= DATA;
        DATA:
          if (r_ready) begin
            r_ready <= !valid;
            r_busy <= valid;
            if (valid) r_shreg <= value;
            else r_state <= IDLE;
          end else begin
            r_ready <= w_pre_end && w_last_bit;
            if (w_sym_end) r_shreg <= {r_shreg[6:0], 1'b0};
          end
        default: r_state <= IDLE;
      endcase
    end
  assign ready = r_ready;
  assign busy = r_busy;
  assign sig = r_sig;
endmodule

// File: tb/tb_psk_modulator.sv
// tb_psk_modulator: randomized bursts checked against a symbol-level model of the transmitter.
`timescale 1ns/1ps
module tb_psk_modulator;
  localparam int SYM = 32;
  localparam int PB = 4;
  logic clk = 1'b0, rst_in = 1'b0, valid = 1'b0, valid0 = 1'b0;
  logic [7:0] value = 8'h00;
  logic ready, busy, sig, ready0, busy0, sig0;
  logic [11:0] m_acc = 12'h0, m_prev = 12'h0;
  logic [2:0] obs[$], expv[$];
  logic tmo;
  int checks = 0, errors = 0;

  psk_modulator #(.CTRL_WORD(12'h100), .SYM_CYCLES(SYM), .PREAMBLE_BITS(PB)) dut (
    .clk(clk), .rst_in(rst_in), .value(value), .valid(valid),
    .ready(ready), .busy(busy), .sig(sig)
  );
  psk_modulator #(.CTRL_WORD(12'h100), .SYM_CYCLES(SYM), .PREAMBLE_BITS(0)) dut0 (
    .clk(clk), .rst_in(rst_in), .value(value), .valid(valid0),
    .ready(ready0), .busy(busy0), .sig(sig0)
  );

  always #5 clk = ~clk;
  // carrier reference: m_prev is the accumulator value that produced the current sig
  always @(posedge clk) begin
    m_prev <= m_acc;
    m_acc <= rst_in ? m_acc + 12'h100 : 12'h0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // expected {busy,ready,sym} per sample, sample 0 taken just after the accepting edge
  task automatic build_model(input logic [7:0] b[$], input int pb);
    logic s[$];
    int d;
`ifdef PSK_DIFF_EN
    logic p;
    p = 1'b0;
`endif
    expv.delete();
    for (int k = 0; k < pb; k++) s.push_back(k % 2 == 0);
    foreach (b[i]) for (int t = 7; t >= 0; t--) s.push_back(b[i][t]);
`ifdef PSK_DIFF_EN
    foreach (s[i]) begin
      p = p ^ s[i];
      s[i] = p;
    end
`endif
    d = s.size() * SYM;
    for (int j = 0; j <= d + 1; j++)
      expv.push_back({j < d, j >= d || (j >= pb * SYM && (j + 1 - pb * SYM) % (8 * SYM) == 0),
                      (j >= 1 && j <= d) ? s[(j - 1) / SYM] : 1'b0});
  endtask

  task automatic drive_burst(input logic [7:0] b[$], input bit noise, input bit sel);
    int k, left, j;
    logic r, bz, sg, v;
    k = 1; left = 0; j = 0;
    obs.delete();
    tmo = 1'b0;
    value = b[0];
    if (sel) valid0 = 1'b1; else valid = 1'b1;
    while (left < 2) begin
      step;
      r = sel ? ready0 : ready;
      bz = sel ? busy0 : busy;
      sg = sel ? sig0 : sig;
      obs.push_back({bz, r, sg ^ m_prev[11]});
      if (k == b.size() && !bz) left++;
      if (r || !noise) begin
        v = k < b.size();
        value = 8'h00;
        if (v) value = b[k];
        if (r && v) k++;
      end else begin
        v = 1'($urandom_range(0, 1));
        value = 8'hFF;
      end
      if (sel) valid0 = v; else valid = v;
      if (++j > 6000) begin
        tmo = 1'b1;
        left = 2;
      end
    end
    valid = 1'b0;
    valid0 = 1'b0;
  endtask

  task automatic test_reset;
    logic [2:0] e;
    repeat (3) begin
      step;
      checks++;
      if ({sig, ready, busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset {sig,ready,busy} got %b exp 000", {sig, ready, busy});
      end
    end
    rst_in = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step;
      e = {((k - 1) * 256) % 4096 >= 2048, 1'b1, 1'b0};
      checks++;
      if ({sig, ready, busy} !== e) begin
        errors++;
        $display("FAIL idle_carrier clk %0d {sig,ready,busy} got %b exp %b", k, {sig, ready, busy}, e);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] b[$];
    b = '{8'hA5};
    build_model(b, PB);
    drive_burst(b, 1'b0, 1'b0);
    checks++;
    if (tmo || obs.size() != expv.size()) begin
      errors++;
      $display("FAIL single length got %0d exp %0d", obs.size(), expv.size());
    end
    foreach (expv[j]) if (j < obs.size()) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL single sample %0d {busy,ready,sym} got %b exp %b", j, obs[j], expv[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b[$];
    b = '{8'hA5, 8'h3C};
    build_model(b, PB);
    drive_burst(b, 1'b0, 1'b0);
    checks++;
    if (tmo || obs.size() != expv.size()) begin
      errors++;
      $display("FAIL b2b length got %0d exp %0d", obs.size(), expv.size());
    end
    foreach (expv[j]) if (j < obs.size()) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL b2b sample %0d {busy,ready,sym} got %b exp %b", j, obs[j], expv[j]);
      end
    end
  endtask

  task automatic test_ignored_valid;
    logic [7:0] b[$];
    b = '{8'h00, 8'hFF, 8'($urandom)};
    build_model(b, PB);
    drive_burst(b, 1'b1, 1'b0);
    checks++;
    if (tmo || obs.size() != expv.size()) begin
      errors++;
      $display("FAIL ignored length got %0d exp %0d", obs.size(), expv.size());
    end
    foreach (expv[j]) if (j < obs.size()) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL ignored sample %0d {busy,ready,sym} got %b exp %b", j, obs[j], expv[j]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b[$];
    bit nz;
    repeat (3) begin
      b.delete();
      repeat ($urandom_range(1, 3)) b.push_back(8'($urandom));
      nz = 1'($urandom_range(0, 1));
      build_model(b, PB);
      drive_burst(b, nz, 1'b0);
      checks++;
      if (tmo || obs.size() != expv.size()) begin
        errors++;
        $display("FAIL random length got %0d exp %0d", obs.size(), expv.size());
      end
      foreach (expv[j]) if (j < obs.size()) begin
        checks++;
        if (obs[j] !== expv[j]) begin
          errors++;
          $display("FAIL random sample %0d {busy,ready,sym} got %b exp %b", j, obs[j], expv[j]);
        end
      end
      repeat ($urandom_range(0, 5)) step;
    end
  endtask

  task automatic test_mid_reset;
    logic [2:0] e;
    value = 8'hA5;
    valid = 1'b1;
    step;
    valid = 1'b0;
    repeat (6 * SYM + 5) step;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset busy before reset got %b exp 1", busy);
    end
    rst_in = 1'b0;
    step;
    checks++;
    if ({sig, ready, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset {sig,ready,busy} got %b exp 000", {sig, ready, busy});
    end
    rst_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step;
      e = {((k - 1) * 256) % 4096 >= 2048, 1'b1, 1'b0};
      checks++;
      if ({sig, ready, busy} !== e) begin
        errors++;
        $display("FAIL mid_reset_idle clk %0d {sig,ready,busy} got %b exp %b", k, {sig, ready, busy}, e);
      end
    end
  endtask

  task automatic test_no_preamble;
    logic [7:0] b[$];
    b = '{8'($urandom)};
    build_model(b, 0);
    drive_burst(b, 1'b0, 1'b1);
    checks++;
    if (tmo || obs.size() != expv.size()) begin
      errors++;
      $display("FAIL no_preamble length got %0d exp %0d", obs.size(), expv.size());
    end
    foreach (expv[j]) if (j < obs.size()) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL no_preamble sample %0d {busy,ready,sym} got %b exp %b", j, obs[j], expv[j]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_ignored_valid;
    test_random;
    test_mid_reset;
    test_no_preamble;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
